timer_arbiter: RTL and testbench



---
 rtl/timer_arbiter.sv | 136 +++++++++++++
 tb/tb_timer_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/timer_arbiter.sv
// Round-robin owner of a single shared one-shot down-counter for N requesters.
// Optional owner-abort during a run is enabled by defining TIMER_ARBITER_ABORT_EN.
module timer_arbiter #(
  parameter  int W  = 8,
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] value,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   done,
  output logic           busy,
  output logic [IW-1:0]  index
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [N-1:0]   done_q, done_d;
  logic [IW-1:0]  index_q, index_d;
  logic [IW-1:0]  last_q, last_d;

  logic           winFound;
  logic [IW-1:0]  winIdx;
  logic [W-1:0]   winValue;
  logic [W-1:0]   loadValue;

  function automatic logic [IW-1:0] wrapIdx(input logic [IW-1:0] base, input int offset);
    int sum;
    sum = (int'(base) + offset) % N;
    return IW'(sum);
  endfunction

  function automatic logic [N-1:0] oneHot(input logic [IW-1:0] idx);
    logic [N-1:0] vec;
    vec = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Search upward from the slot after the previous winner so every holder gets a turn.
  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!winFound && req[wrapIdx(last_q, k)]) begin
        winFound = 1'b1;
        winIdx   = wrapIdx(last_q, k);
      end
    end
  end

  // A zero delay still occupies the timer for one cycle.
  always_comb begin
    winValue  = value[int'(winIdx)*W +: W];
    loadValue = (winValue == '0) ? W'(1) : winValue;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    grant_d = grant_q;
    done_d  = '0;
    index_d = index_q;
    last_d  = last_q;

    case (state_q)
      IDLE: begin
        if (winFound) begin
          count_d = loadValue;
          grant_d = oneHot(winIdx);
          index_d = winIdx;
          last_d  = winIdx;
          state_d = RUN;
        end
      end

      RUN: begin
        // Completion takes priority over an abort sampled at the same edge.
        if (count_q == W'(1)) begin
          count_d = '0;
          done_d  = oneHot(index_q);
          grant_d = '0;
          state_d = IDLE;
        end
`ifdef TIMER_ARBITER_ABORT_EN
        else if (!req[index_q]) begin
          count_d = '0;
          grant_d = '0;
          state_d = IDLE;
        end
`endif
        else begin
          count_d = count_q - W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      index_q <= '0;
      last_q  <= IW'(N - 1);
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      index_q <= index_d;
      last_q  <= last_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = |grant_q;
  assign index = index_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter (W=8, N=4) with hand-computed expectations;
// the abort scenario adapts when TIMER_ARBITER_ABORT_EN is defined.
module tb_timer_arbiter;

   localparam int W = 8;
   localparam int N = 4;

   logic           clock;
   logic           reset;
   logic [N-1:0]   req;
   logic [N*W-1:0] value;
   logic [N-1:0]   grant;
   logic [N-1:0]   done;
   logic           busy;
   logic [1:0]     index;

   int vectorCount;
   int missCount;

   timer_arbiter #(.W(W), .N(N)) dut (
      .clock (clock),
      .reset (reset),
      .req   (req),
      .value (value),
      .grant (grant),
      .done  (done),
      .busy  (busy),
      .index (index)
   );

   // Free-running 10-unit clock; inputs change and outputs are sampled on the falling edge.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Single comparison point: counts every vector and reports any miscompare.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, want %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Drives new request/delay inputs and then lets one rising edge pass.
   task automatic applyStimulus(input logic [N-1:0] newReq, input logic [N*W-1:0] newValue);
      req   = newReq;
      value = newValue;
      @(negedge clock);
   endtask

   task automatic stepCycle();
      @(negedge clock);
   endtask

   task automatic pulseReset();
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   function automatic logic [N*W-1:0] packValues(input logic [W-1:0] v3, input logic [W-1:0] v2,
                                                  input logic [W-1:0] v1, input logic [W-1:0] v0);
      return {v3, v2, v1, v0};
   endfunction

   // Directed scenarios run back to back; each comment states the expected behaviour.
   initial begin
      logic [N-1:0] expGrant;
      logic [N-1:0] expDone;
      vectorCount = 0;
      missCount   = 0;
      reset = 1'b1;
      req   = '0;
      value = '0;
      @(negedge clock);
      @(negedge clock);

      checkOutput("rst_grant", 32'(grant), 32'h0);
      checkOutput("rst_done",  32'(done),  32'h0);
      checkOutput("rst_busy",  32'(busy),  32'h0);
      checkOutput("rst_index", 32'(index), 32'h0);
      reset = 1'b0;

      // Requester 0, delay 5: grant for five cycles, done right after; late value change ignored.
      applyStimulus(4'b0001, packValues(8'd0, 8'd0, 8'd0, 8'd5));
      checkOutput("s1_grant0", 32'(grant), 32'h1);
      checkOutput("s1_busy0",  32'(busy),  32'h1);
      checkOutput("s1_index0", 32'(index), 32'h0);
      applyStimulus(4'b0000, packValues(8'd0, 8'd0, 8'd0, 8'd200));
      for (int k = 2; k <= 4; k++) begin
         checkOutput("s1_grant_run", 32'(grant), 32'h1);
         checkOutput("s1_done_run",  32'(done),  32'h0);
         stepCycle();
      end
      checkOutput("s1_grant4", 32'(grant), 32'h1);
      stepCycle();
      checkOutput("s1_grant5", 32'(grant), 32'h0);
      checkOutput("s1_done5",  32'(done),  32'h1);
      checkOutput("s1_busy5",  32'(busy),  32'h0);
      checkOutput("s1_index5", 32'(index), 32'h0);
      stepCycle();
      checkOutput("s1_done6",  32'(done),  32'h0);

      // Delays 0 and 1 both give a single grant cycle.
      for (int v = 0; v <= 1; v++) begin
         applyStimulus(4'b0001, packValues(8'd0, 8'd0, 8'd0, 8'(v)));
         checkOutput("s2_grant", 32'(grant), 32'h1);
         applyStimulus(4'b0000, value);
         checkOutput("s2_grant_end", 32'(grant), 32'h0);
         checkOutput("s2_done",      32'(done),  32'h1);
         stepCycle();
         checkOutput("s2_done_clr",  32'(done),  32'h0);
      end

      // All four hold req with delay 2: rotation 0,1,2,3,0 with a 3-cycle period.
      pulseReset();
      applyStimulus(4'b1111, packValues(8'd2, 8'd2, 8'd2, 8'd2));
      for (int c = 0; c <= 14; c++) begin
         expGrant = (c % 3 < 2) ? 4'(1 << ((c / 3) % 4)) : 4'b0000;
         expDone  = (c % 3 == 2) ? 4'(1 << ((c / 3) % 4)) : 4'b0000;
         checkOutput("s3_grant", 32'(grant), 32'(expGrant));
         checkOutput("s3_done",  32'(done),  32'(expDone));
         if (c % 3 < 2) checkOutput("s3_index", 32'(index), 32'((c / 3) % 4));
         if (c == 14) req = 4'b0000;
         stepCycle();
      end
      checkOutput("s3_idle", 32'(grant), 32'h0);

      // Last winner was 0, so with req=0101 requester 2 goes before requester 0.
      applyStimulus(4'b0101, packValues(8'd2, 8'd2, 8'd2, 8'd2));
      checkOutput("s4_first",  32'(grant), 32'h4);
      stepCycle();
      stepCycle();
      checkOutput("s4_done2",  32'(done),  32'h4);
      stepCycle();
      checkOutput("s4_second", 32'(grant), 32'h1);
      req = 4'b0000;
      stepCycle();
      stepCycle();
      checkOutput("s4_done0",  32'(done),  32'h1);

      // Reset at count 3 of a 10-cycle run aborts it silently.
      applyStimulus(4'b0001, packValues(8'd0, 8'd0, 8'd3, 8'd10));
      checkOutput("s5_grant", 32'(grant), 32'h1);
      req = 4'b0000;
      for (int k = 1; k <= 7; k++) stepCycle();
      checkOutput("s5_mid", 32'(grant), 32'h1);
      pulseReset();
      checkOutput("s5_rst_grant", 32'(grant), 32'h0);
      checkOutput("s5_rst_busy",  32'(busy),  32'h0);
      checkOutput("s5_rst_done",  32'(done),  32'h0);
      checkOutput("s5_rst_index", 32'(index), 32'h0);
      for (int k = 0; k < 4; k++) begin
         stepCycle();
         checkOutput("s5_no_done", 32'(done), 32'h0);
      end
      applyStimulus(4'b0010, packValues(8'd0, 8'd0, 8'd3, 8'd10));
      checkOutput("s5_regrant", 32'(grant), 32'h2);
      checkOutput("s5_index",   32'(index), 32'h1);
      req = 4'b0000;
      stepCycle();
      stepCycle();
      stepCycle();
      checkOutput("s5_done", 32'(done), 32'h2);
      stepCycle();

      // Requester 1, delay 8, drops req while count is 4.
      applyStimulus(4'b0010, packValues(8'd0, 8'd0, 8'd8, 8'd0));
      checkOutput("s6_grant", 32'(grant), 32'h2);
      for (int k = 1; k <= 9; k++) begin
         if (k == 5) req = 4'b0000;
         stepCycle();
`ifdef TIMER_ARBITER_ABORT_EN
         expGrant = (k < 5) ? 4'b0010 : 4'b0000;
         expDone  = 4'b0000;
`else
         expGrant = (k < 8) ? 4'b0010 : 4'b0000;
         expDone  = (k == 8) ? 4'b0010 : 4'b0000;
`endif
         checkOutput("s6_grant_k", 32'(grant), 32'(expGrant));
         checkOutput("s6_done_k",  32'(done),  32'(expDone));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
